// File: rtl/a_trace_pkg.sv
// Shared trace RAM geometry and capture/readout state encoding for the trace controller slice.
// Pure declarations; no logic, no latency.
package a_trace_pkg;

  localparam int TRACE_DATA_W     = 64;
  localparam int TRACE_ADDR_W     = 13;
  localparam int TRACE_FULL_LEVEL = 8183;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_POST,
    ST_DONE,
    ST_RFILL,
    ST_READ
  } state_t;

endpackage

// File: rtl/a_trace_rd_seq.sv
// Readout pointer/count with lookahead RAM read address so a registered RAM streams one word per cycle.
// out_valid is combinational from state; a stall holds rptr, so the RAM keeps presenting the current word.
module a_trace_rd_seq #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_read,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              out_last,
  output logic              fire,
  output logic [ADDR_W-1:0] rdaddr
);

  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   rcnt;

  assign out_valid = in_read;
  assign out_last  = in_read & (rcnt == (ADDR_W+1)'(1));
  assign fire      = out_valid & out_ready;
  // Address the next word on an accept so it lands in the RAM output register in time for the next cycle.
  assign rdaddr    = fire ? rptr + 1'b1 : rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= '0;
      rcnt <= '0;
    end else if (load) begin
      rptr <= start;
      rcnt <= len;
    end else if (fire) begin
      rptr <= rptr + 1'b1;
      rcnt <= rcnt - 1'b1;
    end
  end

endmodule

// File: rtl/a_trace_ctrl.sv
// Trace capture/readout sequencer: circular capture with post-trigger count, then oldest-first streaming readout.
// Writes are combinational from smp_valid; readout is one word per cycle after a 1-cycle fill, stalls on out_ready low.
module a_trace_ctrl
  import a_trace_pkg::*;
#(
  parameter int DATA_W     = TRACE_DATA_W,
  parameter int ADDR_W     = TRACE_ADDR_W,
  parameter int FULL_LEVEL = TRACE_FULL_LEVEL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic [ADDR_W-1:0] post_len,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              rd_start,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [DATA_W-1:0] ram_din,
  output logic [ADDR_W-1:0] ram_rdaddr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              wrapped
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wptr, plen, pcnt, plen_in, win_start;
  logic [ADDR_W:0]   win_len;
  logic              arm_ok, wr, trig_hit, rd_go, rd_fire, rd_last;

  assign plen_in   = (post_len > ADDR_W'(FULL_LEVEL)) ? ADDR_W'(FULL_LEVEL) : post_len;
  assign arm_ok    = arm & ~abort & ((state == ST_IDLE) | (state == ST_DONE));
  assign wr        = smp_valid & ~abort & ((state == ST_PRE) | (state == ST_POST));
  assign trig_hit  = wr & trig & (state == ST_PRE);
  assign win_start = wrapped ? wptr : '0;
  assign win_len   = wrapped ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, wptr};
  // arm wins over rd_start in DONE; an empty window never starts a readout.
  assign rd_go     = rd_start & ~arm & ~abort & (state == ST_DONE) & (win_len != '0);

  assign ram_wen    = wr;
  assign ram_wraddr = wptr;
  assign ram_din    = smp_data;
  assign out_data   = out_valid ? ram_dout : '0;
  assign busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign done       = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (arm) state_nxt = ST_PRE;
        ST_PRE:   if (trig_hit) state_nxt = (plen == '0) ? ST_DONE : ST_POST;
        ST_POST:  if (wr && pcnt == ADDR_W'(1)) state_nxt = ST_DONE;
        ST_DONE: begin
          if (arm)        state_nxt = ST_PRE;
          else if (rd_go) state_nxt = ST_RFILL;
        end
        ST_RFILL: state_nxt = ST_READ;
        ST_READ:  if (rd_fire && rd_last) state_nxt = ST_DONE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      wrapped   <= 1'b0;
      trig_addr <= '0;
      plen      <= '0;
      pcnt      <= '0;
    end else if (arm_ok) begin
      wptr      <= '0;
      wrapped   <= 1'b0;
      trig_addr <= '0;
      plen      <= plen_in;
    end else begin
      if (wr) begin
        wptr <= wptr + 1'b1;
        if (wptr == {ADDR_W{1'b1}}) wrapped <= 1'b1;
      end
      if (trig_hit) begin
        trig_addr <= wptr;
        pcnt      <= plen;
      end else if (wr && state == ST_POST) begin
        pcnt <= pcnt - 1'b1;
      end
    end
  end

  a_trace_rd_seq #(.ADDR_W(ADDR_W)) u_rd_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (rd_go),
    .start     (win_start),
    .len       (win_len),
    .in_read   ((state == ST_READ) & ~abort),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_last  (rd_last),
    .fire      (rd_fire),
    .rdaddr    (ram_rdaddr)
  );

  assign out_last = rd_last;

endmodule

// File: tb/tb_a_trace_ctrl.sv
// Self-checking bench for a_trace_ctrl: behavioural RAM, sample-history model and randomized capture/readout.
module tb_a_trace_ctrl;

  localparam int AW    = 13;
  localparam int DW    = 64;
  localparam int DEPTH = 8192;
  localparam int FULL  = 8183;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0, abort = 1'b0, trig = 1'b0, smp_valid = 1'b0, rd_start = 1'b0;
  logic [AW-1:0] post_len = '0;
  logic [DW-1:0] smp_data = '0;
  logic          out_ready = 1'b0;
  logic          ram_wen, out_valid, out_last, busy, done, wrapped;
  logic [AW-1:0] ram_wraddr, ram_rdaddr, trig_addr;
  logic [DW-1:0] ram_din, out_data;
  logic [DW-1:0] ram_dout = '0;

  always #5 clk = ~clk;

  a_trace_ctrl dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig(trig), .post_len(post_len),
    .smp_valid(smp_valid), .smp_data(smp_data), .rd_start(rd_start),
    .ram_wen(ram_wen), .ram_wraddr(ram_wraddr), .ram_din(ram_din), .ram_rdaddr(ram_rdaddr),
    .ram_dout(ram_dout), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done), .trig_addr(trig_addr), .wrapped(wrapped)
  );

  // Trace RAM with a registered read port.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_wraddr] <= ram_din;
    ram_dout <= mem[ram_rdaddr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: every sample written since arm, in order.
  logic [63:0] hist[$];
  int m_count = 0, m_trig_idx = 0, m_post_left = 0, m_plen = 0;
  bit m_cap = 0, m_trig_seen = 0, m_done = 0;

  task automatic do_arm(input int len);
    arm = 1'b1;
    post_len = AW'(len);
    @(posedge clk); #1;
    arm = 1'b0;
    hist.delete();
    m_count = 0; m_trig_seen = 0; m_cap = 1; m_done = 0;
    m_plen = (len > FULL) ? FULL : len;
    check("arm_busy", busy, 1);
    check("arm_wrapped", wrapped, 0);
    check("arm_trig_addr", trig_addr, 0);
  endtask

  task automatic cap_cycle(input bit v, input bit t, input logic [63:0] d);
    bit exp_wen;
    smp_valid = v; trig = t; smp_data = d;
    #4;
    exp_wen = v && m_cap;
    check("wen", ram_wen, exp_wen);
    if (exp_wen) begin
      check("wraddr", ram_wraddr, m_count % DEPTH);
      check("din", ram_din, d);
    end
    @(posedge clk);
    if (exp_wen) begin
      hist.push_back(d);
      if (!m_trig_seen) begin
        if (t) begin
          m_trig_seen = 1; m_trig_idx = m_count; m_post_left = m_plen;
          if (m_plen == 0) begin m_cap = 0; m_done = 1; end
        end
      end else begin
        m_post_left--;
        if (m_post_left == 0) begin m_cap = 0; m_done = 1; end
      end
      m_count++;
    end
    #1;
    check("done", done, m_done);
    check("busy", busy, m_cap);
    smp_valid = 1'b0; trig = 1'b0;
  endtask

  task automatic feed(input int trig_at, input bit rnd, input bit idx_data);
    int budget = 40000;
    while (m_cap && budget > 0) begin
      bit v, t;
      logic [63:0] d;
      v = rnd ? ($urandom % 4 != 0) : 1'b1;
      t = m_trig_seen ? bit'($urandom % 2) : (m_count >= trig_at);
      d = idx_data ? 64'(m_count) : {$urandom, $urandom};
      cap_cycle(v, t, d);
      budget--;
    end
    if (m_cap) check("feed_timeout", 0, 1);
    check("trig_addr", trig_addr, m_trig_idx % DEPTH);
    check("wrapped", wrapped, m_count >= DEPTH);
  endtask

  task automatic readout(input bit rnd);
    int n, base, idx, stall, cyc;
    bit r;
    n = (m_count >= DEPTH) ? DEPTH : m_count;
    base = hist.size() - n;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    check("rfill_vld", out_valid, 0);
    check("rfill_busy", busy, 1);
    @(posedge clk); #1;
    idx = 0; stall = 0; cyc = 0;
    while (idx < n && cyc < n * 8 + 64) begin
      if (!rnd)                   r = 1'b1;
      else if (stall > 0)         begin r = 1'b0; stall--; end
      else if ($urandom % 16 == 0) begin r = 1'b0; stall = 4; end
      else                        r = ($urandom % 4 != 0);
      out_ready = r;
      #4;
      check("rd_vld", out_valid, 1);
      check("rd_dat", out_data, hist[base + idx]);
      check("rd_last", out_last, idx == n - 1);
      @(posedge clk); #1;
      if (r) idx++;
      cyc++;
    end
    out_ready = 1'b0;
    if (idx < n) check("rd_timeout", 64'(idx), 64'(n));
    check("rd_end_vld", out_valid, 0);
    check("rd_end_done", done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wen"}, ram_wen, 0);
    check({tag, "_wraddr"}, ram_wraddr, 0);
    check({tag, "_rdaddr"}, ram_rdaddr, 0);
    check({tag, "_vld"}, out_valid, 0);
    check({tag, "_dat"}, out_data, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_taddr"}, trig_addr, 0);
    check({tag, "_wrap"}, wrapped, 0);
  endtask

  initial begin
    #12;
    check_all_zero("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Short capture: trigger on 6th sample, 4 post samples, data = index.
    do_arm(4);
    feed(5, 1'b0, 1'b1);
    check("t1_taddr", trig_addr, 5);
    readout(1'b1);

    // Abort in POST while a sample is presented.
    do_arm(3);
    cap_cycle(1'b1, 1'b1, 64'h1234);
    cap_cycle(1'b1, 1'b0, 64'h5678);
    smp_valid = 1'b1; abort = 1'b1;
    #4;
    check("abort_wen", ram_wen, 0);
    @(posedge clk); #1;
    abort = 1'b0; smp_valid = 1'b0;
    m_cap = 0; m_done = 0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    do_arm(2);
    feed(3, 1'b0, 1'b1);
    readout(1'b0);

    // Wrapped capture: 9000 samples before the trigger, 100 after.
    do_arm(100);
    feed(9000, 1'b1, 1'b0);
    check("t2_taddr", trig_addr, 808);
    readout(1'b0);

    // Clamped post length with stalled readout.
    do_arm(8191);
    feed(50, 1'b1, 1'b0);
    readout(1'b1);

    // Reset mid-readout, then rd_start must be ignored.
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("pre_rst_vld", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b0;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("post_rst_busy", busy, 0);
    check("post_rst_vld", out_valid, 0);
    check("post_rst_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
